// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/memory arbiter slice.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        STORE  = 2'd3
    } arb_state_t;

    localparam int unsigned WORD_IDX_W  = 3;
    localparam int unsigned DEF_MEM_LAT = 4;

endpackage

// File: rtl/cache_mem_arbiter_word_pipe.sv
// Read-tag pipeline: carries {valid, word index} from read enable to returning data.
module dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

module arb_word_pipe #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned IDX_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    input  logic [IDX_W-1:0] push_idx_i,
    output logic             pop_valid_o,
    output logic [IDX_W-1:0] pop_idx_o
);

    logic [MEM_LAT:0][IDX_W:0] stage;

    assign stage[0] = {push_valid_i, push_idx_i};

    for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_stage
        dff #(.W(IDX_W + 1)) u_dff (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (stage[gi]),
            .q_o   (stage[gi+1])
        );
    end

    assign pop_valid_o = stage[MEM_LAT][IDX_W];
    assign pop_idx_o   = stage[MEM_LAT][IDX_W-1:0];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-miss, D-miss and D write-through onto the shared memory port.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_LAT   = DEF_MEM_LAT,
    parameter int unsigned WR_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_miss,
    input  logic [ADDR_W-1:0]     icache_addr,
    input  logic                  dcache_miss,
    input  logic [ADDR_W-1:0]     dcache_addr,
    input  logic                  dcache_wr_req,
    input  logic [ADDR_W-1:0]     dcache_wr_addr,
    input  logic [DATA_W-1:0]     dcache_wr_data,
    output logic                  dcache_wr_ack,
    output logic                  fill_miss,
    output logic [ADDR_W-1:0]     fill_addr,
    input  logic [ADDR_W-1:0]     fill_mem_addr,
    input  logic                  fill_tag_write,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_data_in,
    input  logic                  mem_data_valid,
    input  logic [DATA_W-1:0]     mem_data_out,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  icache_fill_we,
    output logic                  dcache_fill_we,
    output logic                  icache_tag_we,
    output logic                  dcache_tag_we,
    output logic                  icache_stall,
    output logic                  dcache_stall
);

    localparam int unsigned CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    arb_state_t          state_q, state_d;
    logic                last_d_q, last_d_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;

    logic                  pipe_valid;
    logic [WORD_IDX_W-1:0] pipe_idx;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // last_d_q set means the most recent completed fill served the D-cache.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            IDLE: begin
                if (dcache_miss && last_d_q && icache_miss) begin
                    state_d = FILL_I;
                    addr_d  = icache_addr;
                end else if (dcache_miss) begin
                    state_d = FILL_D;
                    addr_d  = dcache_addr;
                end else if (dcache_wr_req) begin
                    state_d = STORE;
                    addr_d  = dcache_wr_addr;
                    wdata_d = dcache_wr_data;
                    wcnt_d  = CNT_W'(WR_CYCLES - 1);
                end else if (icache_miss) begin
                    state_d = FILL_I;
                    addr_d  = icache_addr;
                end
            end
            FILL_I: begin
                if (fill_tag_write) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end
            end
            FILL_D: begin
                if (fill_tag_write) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end
            end
            STORE: begin
                if (wcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_miss      = 1'b0;
        fill_addr      = '0;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_data_in    = '0;
        dcache_wr_ack  = 1'b0;
        icache_fill_we = 1'b0;
        dcache_fill_we = 1'b0;
        icache_tag_we  = 1'b0;
        dcache_tag_we  = 1'b0;
        case (state_q)
            FILL_I, FILL_D: begin
                fill_miss  = 1'b1;
                fill_addr  = addr_q;
                mem_enable = 1'b1;
                mem_addr   = fill_mem_addr;
                if (state_q == FILL_I) begin
                    icache_fill_we = mem_data_valid;
                    icache_tag_we  = fill_tag_write;
                end else begin
                    dcache_fill_we = mem_data_valid;
                    dcache_tag_we  = fill_tag_write;
                end
            end
            STORE: begin
                mem_enable    = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = addr_q;
                mem_data_in   = wdata_q;
                dcache_wr_ack = (wcnt_q == '0);
            end
            default: ;
        endcase
        icache_stall = icache_miss | (state_q == FILL_I);
        dcache_stall = dcache_miss | (state_q == FILL_D) | (dcache_wr_req & ~dcache_wr_ack);
    end

    arb_word_pipe #(
        .MEM_LAT (MEM_LAT),
        .IDX_W   (WORD_IDX_W)
    ) u_word_pipe (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .push_valid_i (mem_enable & ~mem_wr),
        .push_idx_i   (fill_mem_addr[3:1]),
        .pop_valid_o  (pipe_valid),
        .pop_idx_o    (pipe_idx)
    );

    assign fill_data = mem_data_out;
    assign fill_word = pipe_valid ? pipe_idx : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: models the fill FSM and an enable-held multicycle memory, scoreboards returned words.
module tb_cache_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        icache_miss = 1'b0, dcache_miss = 1'b0, dcache_wr_req = 1'b0;
    logic [15:0] icache_addr = '0, dcache_addr = '0, dcache_wr_addr = '0, dcache_wr_data = '0;
    logic        dcache_wr_ack, fill_miss, mem_enable, mem_wr;
    logic [15:0] fill_addr, mem_addr, mem_data_in, fill_data;
    logic [15:0] fill_mem_addr = '0;
    logic [15:0] mem_data_out = '0;
    logic        mdl_valid = 1'b0, mdl_tag = 1'b0, stray_v = 1'b0, stray_tag = 1'b0;
    logic        mem_data_valid, fill_tag_write;
    logic [2:0]  fill_word;
    logic        icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we;
    logic        icache_stall, dcache_stall;

    assign mem_data_valid = mdl_valid | stray_v;
    assign fill_tag_write = mdl_tag | stray_tag;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_LAT   (LAT),
        .WR_CYCLES (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_miss    (icache_miss),
        .icache_addr    (icache_addr),
        .dcache_miss    (dcache_miss),
        .dcache_addr    (dcache_addr),
        .dcache_wr_req  (dcache_wr_req),
        .dcache_wr_addr (dcache_wr_addr),
        .dcache_wr_data (dcache_wr_data),
        .dcache_wr_ack  (dcache_wr_ack),
        .fill_miss      (fill_miss),
        .fill_addr      (fill_addr),
        .fill_mem_addr  (fill_mem_addr),
        .fill_tag_write (fill_tag_write),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .mem_data_out   (mem_data_out),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .icache_fill_we (icache_fill_we),
        .dcache_fill_we (dcache_fill_we),
        .icache_tag_we  (icache_tag_we),
        .dcache_tag_we  (dcache_tag_we),
        .icache_stall   (icache_stall),
        .dcache_stall   (dcache_stall)
    );

    typedef struct packed {
        logic        ifw;
        logic        dfw;
        logic [2:0]  word;
        logic [15:0] data;
    } fill_exp_t;

    fill_exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int i_tags = 0;
    int d_tags = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_fill(input logic is_i, input logic [15:0] base, input int n);
        fill_exp_t  e;
        logic [2:0] wv;
        for (int w = 0; w < n; w++) begin
            wv     = w[2:0];
            e.ifw  = is_i;
            e.dfw  = ~is_i;
            e.word = wv;
            e.data = {base[15:4], wv, 1'b0} ^ 16'h5A5A;
            exp_q.push_back(e);
        end
    endtask

    // Memory holds one access in flight; dropping enable or switching to write cancels it.
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [15:0] maddr = '0;
    int          fm_word = 0;
    logic [2:0]  fm_idx;

    always @(posedge clk) begin
        #1;
        mdl_valid = 1'b0;
        if (mbusy) begin
            mcnt--;
            if (mcnt == 0) begin
                mdl_valid    = 1'b1;
                mem_data_out = maddr ^ 16'h5A5A;
                mbusy        = 1'b0;
            end
        end
        if (!fill_miss) begin
            fm_word       = 0;
            mdl_tag       = 1'b0;
            fill_mem_addr = '0;
        end else begin
            mdl_tag = (fm_word == 8);
            if (mdl_valid && fm_word < 8) fm_word++;
            fm_idx        = (fm_word > 7) ? 3'd7 : fm_word[2:0];
            fill_mem_addr = {fill_addr[15:4], fm_idx, 1'b0};
        end
        #1;
        if (mbusy && !(mem_enable && !mem_wr)) mbusy = 1'b0;
        if (!mbusy && mem_enable && !mem_wr) begin
            mbusy = 1'b1;
            mcnt  = LAT;
            maddr = mem_addr;
        end
    end

    always @(posedge clk) begin
        fill_exp_t e;
        #3;
        if (icache_tag_we) i_tags++;
        if (dcache_tag_we) d_tags++;
        if (icache_fill_we || dcache_fill_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fill", 32'({icache_fill_we, dcache_fill_we}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("fill_beat", 32'({icache_fill_we, dcache_fill_we, fill_word, fill_data}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic wait_fill_done(input int budget);
        int n = 0;
        while (fill_miss && n < budget) begin
            tick();
            n++;
        end
        chk("fill_done_in_time", 32'(fill_miss), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #4;
        chk("rst_fill_miss", 32'(fill_miss), 32'd0);
        chk("rst_mem_en_wr", 32'({mem_enable, mem_wr}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        chk("rst_fill_word", 32'(fill_word), 32'd0);
        chk("rst_fill_addr", 32'(fill_addr), 32'd0);
        chk("rst_enables", 32'({icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we, dcache_wr_ack}), 32'd0);
        chk("rst_stalls", 32'({icache_stall, dcache_stall}), 32'd0);
        rst_n = 1'b0;
        tick();

        stray_v = 1'b1;
        stray_tag = 1'b1;
        #1;
        chk("stray_idle_enables", 32'({icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we}), 32'd0);
        stray_v = 1'b0;
        stray_tag = 1'b0;

        icache_miss = 1'b1;
        icache_addr = 16'h1234;
        push_fill(1'b1, 16'h1234, 8);
        #1;
        chk("imiss_stall_idle", 32'(icache_stall), 32'd1);
        chk("imiss_not_yet", 32'(fill_miss), 32'd0);
        tick();
        chk("imiss_fill_miss", 32'(fill_miss), 32'd1);
        chk("imiss_fill_addr", 32'(fill_addr), 32'h1234);
        chk("imiss_mem_rd", 32'({mem_enable, mem_wr}), 32'b10);
        chk("imiss_mem_addr", 32'(mem_addr), 32'h1230);
        chk("imiss_dstall", 32'(dcache_stall), 32'd0);
        icache_miss = 1'b0;
        #1;
        chk("imiss_stall_held", 32'(icache_stall), 32'd1);
        wait_fill_done(60);
        chk("imiss_idle_mem_en", 32'(mem_enable), 32'd0);
        chk("imiss_i_tags", 32'(i_tags), 32'd1);
        chk("imiss_d_tags", 32'(d_tags), 32'd0);
        chk("imiss_sb_empty", 32'(exp_q.size()), 32'd0);

        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        dcache_miss = 1'b1;
        dcache_addr = 16'h2200;
        icache_miss = 1'b1;
        icache_addr = 16'h3300;
        push_fill(1'b0, 16'h2200, 8);
        push_fill(1'b1, 16'h3300, 8);
        tick();
        chk("pair1_d_first", 32'(fill_addr), 32'h2200);
        chk("pair1_stalls", 32'({icache_stall, dcache_stall}), 32'b11);
        dcache_miss = 1'b0;
        wait_fill_done(60);
        chk("pair1_gap_istall", 32'(icache_stall), 32'd1);
        tick();
        chk("pair1_i_second", 32'({fill_miss, fill_addr}), 32'h1_3300);
        icache_miss = 1'b0;
        wait_fill_done(60);

        dcache_miss = 1'b1;
        dcache_addr = 16'h4400;
        push_fill(1'b0, 16'h4400, 8);
        tick();
        chk("lone_d_addr", 32'(fill_addr), 32'h4400);
        dcache_miss = 1'b0;
        wait_fill_done(60);

        dcache_miss = 1'b1;
        dcache_addr = 16'h5500;
        icache_miss = 1'b1;
        icache_addr = 16'h6600;
        push_fill(1'b1, 16'h6600, 8);
        push_fill(1'b0, 16'h5500, 8);
        tick();
        chk("pair2_i_first", 32'(fill_addr), 32'h6600);
        icache_miss = 1'b0;
        wait_fill_done(60);
        tick();
        chk("pair2_d_second", 32'({fill_miss, fill_addr}), 32'h1_5500);
        dcache_miss = 1'b0;
        wait_fill_done(60);

        dcache_wr_req = 1'b1;
        dcache_wr_addr = 16'h00A0;
        dcache_wr_data = 16'hBEEF;
        #1;
        chk("store_req_stall", 32'(dcache_stall), 32'd1);
        tick();
        chk("store_mem_en_wr", 32'({mem_enable, mem_wr}), 32'b11);
        chk("store_mem_addr", 32'(mem_addr), 32'h00A0);
        chk("store_mem_data", 32'(mem_data_in), 32'hBEEF);
        chk("store_ack", 32'(dcache_wr_ack), 32'd1);
        chk("store_stall_ack", 32'(dcache_stall), 32'd0);
        dcache_wr_req = 1'b0;
        tick();
        chk("store_after_idle", 32'({mem_enable, mem_wr, dcache_wr_ack}), 32'd0);
        chk("store_after_addr", 32'(mem_addr), 32'd0);

        dcache_wr_req = 1'b1;
        dcache_wr_addr = 16'h0B00;
        dcache_wr_data = 16'h1357;
        tick();
        icache_miss = 1'b1;
        icache_addr = 16'h7700;
        push_fill(1'b1, 16'h7700, 8);
        dcache_wr_req = 1'b0;
        #1;
        chk("st_i_stall", 32'(icache_stall), 32'd1);
        chk("st_i_store_busy", 32'({mem_wr, dcache_wr_ack, fill_miss}), 32'b110);
        tick();
        chk("st_i_idle_gap", 32'({fill_miss, mem_enable, icache_stall}), 32'b001);
        tick();
        chk("st_i_granted", 32'({fill_miss, fill_addr}), 32'h1_7700);
        icache_miss = 1'b0;
        wait_fill_done(60);

        dcache_miss = 1'b1;
        dcache_addr = 16'h8800;
        push_fill(1'b0, 16'h8800, 1);
        tick();
        chk("rstmid_granted", 32'({fill_miss, fill_addr}), 32'h1_8800);
        dcache_miss = 1'b0;
        repeat (7) tick();
        chk("rstmid_still_fill", 32'(fill_miss), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("rstmid_async", 32'({fill_miss, mem_enable}), 32'd0);
        tick();
        chk("rstmid_fill_miss", 32'(fill_miss), 32'd0);
        chk("rstmid_enables", 32'({icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we}), 32'd0);
        chk("rstmid_pipe_empty", 32'(fill_word), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rstmid_idle", 32'({fill_miss, mem_enable, fill_word}), 32'd0);

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("final_i_tags", 32'(i_tags), 32'd4);
        chk("final_d_tags", 32'(d_tags), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the I-cache and D-cache controllers and the single shared multicycle memory port, directly upstream of cache_fill_FSM.
- Picks one requester (D-miss, D-store write-through, or I-miss) and holds the grant until it completes.
- While a fill is granted, drives cache_fill_FSM's miss inputs and routes memory read data back, tagged with its word index, to the requesting cache's data array.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, memory word width
MEM_LAT, 4, memory read latency in cycles (enable to data_valid)
WR_CYCLES, 1, cycles mem_wr is held for one store

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-high (name kept per codebase)
icache_miss  in  1  I-cache tag miss
icache_addr  in  ADDR_W  I-cache miss address
dcache_miss  in  1  D-cache tag miss
dcache_addr  in  ADDR_W  D-cache miss address
dcache_wr_req  in  1  write-through store request
dcache_wr_addr  in  ADDR_W  store address
dcache_wr_data  in  DATA_W  store data
dcache_wr_ack  out  1  one-cycle pulse, store done
fill_miss  out  1  to cache_fill_FSM miss_detected
fill_addr  out  ADDR_W  to cache_fill_FSM miss_address
fill_mem_addr  in  ADDR_W  from cache_fill_FSM memory_address
fill_tag_write  in  1  from cache_fill_FSM write_tag_array
mem_enable  out  1  memory access enable
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_data_valid  in  1  read data valid
mem_data_out  in  DATA_W  read data
fill_data  out  DATA_W  returning word (= mem_data_out)
fill_word  out  3  word index of fill_data within block
icache_fill_we / dcache_fill_we  out  1 each  data-array write enables
icache_tag_we / dcache_tag_we  out  1 each  tag-array write enables
icache_stall / dcache_stall  out  1 each  pipeline stalls

Behaviour:
- States: IDLE, FILL_I, FILL_D, STORE.
- Reset (async, rst_n=1, also mid-operation):
  - state to IDLE; grant history to D; word pipeline cleared.
  - All outputs 0; fill_word 0; fill_miss dropping resets cache_fill_FSM.
- IDLE arbitration, evaluated each cycle, transition at next edge:
  - dcache_miss wins, unless last completed fill was D and icache_miss is pending; then I wins.
  - Otherwise dcache_wr_req goes to STORE.
  - Otherwise icache_miss goes to FILL_I.
  - dcache_miss and dcache_wr_req are never both high; if they are, the miss wins.
- On grant: latch the requester's address into fill_addr (or wr addr/data). Requester inputs are then ignored until exit.
- FILL_I / FILL_D:
  - fill_miss=1; mem_enable=1, mem_wr=0, mem_addr=fill_mem_addr.
  - Exit to IDLE on the cycle after fill_tag_write=1; record the grant history.
  - Re-arbitration happens in the following IDLE cycle, so there are no back-to-back grants without one IDLE cycle.
- Word pipeline:
  - MEM_LAT-deep shift register carries {valid, fill_mem_addr[3:1]}; pushes valid only on read enables.
  - fill_word is the pipeline output, aligned with mem_data_valid.
  - x_fill_we = mem_data_valid & (state==FILL_x); x_tag_we = fill_tag_write & (state==FILL_x).
- STORE:
  - mem_enable=1, mem_wr=1, latched address and data, held WR_CYCLES cycles via a down-counter.
  - On the last cycle, dcache_wr_ack=1 for one cycle; then IDLE.
- IDLE outputs: mem_enable=0, mem_addr=0, mem_data_in=0.
- Stalls:
  - icache_stall = icache_miss | state==FILL_I.
  - dcache_stall = dcache_miss | state==FILL_D | (dcache_wr_req & ~dcache_wr_ack).
- mem_data_valid outside FILL states is ignored: no write enables.
- Requester dropping its miss mid-fill: fill still completes.

Decomposition:
- Package cache_arb_pkg: state enum arb_state_t {IDLE, FILL_I, FILL_D, STORE}; WORD_IDX_W=3; default MEM_LAT.
- Sub-module arb_word_pipe: MEM_LAT-stage valid + index shift register built from dff.
- Arbiter FSM and output muxing stay in the top module.

Test Plan:
- Reset mid-FILL_D (8 cycles in) -> next cycle fill_miss=0, state IDLE, all write enables 0, word pipeline empty.
- Lone icache_miss, addr 0x1234 -> fill_addr=0x1234 one cycle later, FILL_I; memory model returns words; icache_fill_we pulses 8× with fill_word 0..7; icache_tag_we once; IDLE after tag write; dcache_* enables stay 0.
- icache_miss and dcache_miss same cycle, reset history -> D served first, then one IDLE cycle, then I; a second simultaneous pair is served I first.
- dcache_wr_req addr 0x00A0, data 0xBEEF, WR_CYCLES=1 -> next cycle mem_enable=1, mem_wr=1, mem_addr=0x00A0, mem_data_in=0xBEEF, dcache_wr_ack=1; IDLE after.
- icache_miss arrives during STORE -> stays pending and icache_stall=1 until granted after the store completes.
- Stray mem_data_valid while IDLE -> no fill or tag enables asserted.
